// File: rtl/aes_inv_cipher_if.sv
// rtl/aes_inv_cipher_if.sv - block handshake and round-key bus for the AES inverse-cipher sequencer
interface aes_inv_cipher_if #(
  parameter int RK_IDX_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_data;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [127:0]        rk;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;
  logic                busy;

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// rtl/aes_inv_cipher_ctrl.sv - iterative AES-128 inverse cipher, one round per clock
// Byte 0 sits at [127:120]; state bytes are column-major (byte r+4c = row r, column c).
module aes_inv_cipher_ctrl #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  aes_inv_cipher_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [RK_IDX_W-1:0] cnt_q, cnt_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Outputs decode straight from the registers so reset clears them without waiting for an edge
  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_data  = (fsm_q == DONE) ? state_q : '0;
  assign bus.busy      = (fsm_q == ROUND) || (fsm_q == FINAL);
  assign bus.rk_idx    = (fsm_q == ROUND) ? cnt_q :
                         (fsm_q == FINAL) ? '0 : RK_IDX_W'(NR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= RK_IDX_W'(NR - 1);
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_data ^ bus.rk;
          cnt_d   = RK_IDX_W'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_q)) ^ bus.rk);
        if (cnt_q == RK_IDX_W'(1)) fsm_d = FINAL;
        else                       cnt_d = cnt_q - 1'b1;
      end
      FINAL: begin
        state_d = inv_sub_bytes(inv_shift_rows(state_q)) ^ bus.rk;
        fsm_d   = DONE;
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb/tb_aes_inv_cipher_ctrl.sv - directed FIPS-197 C.1 bench for aes_inv_cipher_ctrl
`timescale 1ns/1ps
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] X_M = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] Y_M = 128'hffffffff00000000a5a5a5a55a5a5a5a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alt = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   acc_cyc = 0;
  int   acc_prev = 0;
  logic [127:0] rk_tab [0:10];

  aes_inv_cipher_if #(.RK_IDX_W(4)) bus ();

  aes_inv_cipher_ctrl #(.NR(10), .RK_IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store; alt mode folds masks into rk10/rk0 so ciphertext CT^X decrypts to PT^Y
  always_comb begin
    bus.rk = (bus.rk_idx <= 4'd10) ? rk_tab[bus.rk_idx] : '0;
    if (alt && bus.rk_idx == 4'd10) bus.rk = bus.rk ^ X_M;
    if (alt && bus.rk_idx == 4'd0)  bus.rk = bus.rk ^ Y_M;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_rk_idx"},    bus.rk_idx, 10);
  endtask

  // Called at a negedge with the DUT in IDLE; ends at the negedge after the output handshake
  task automatic run_block(input logic [127:0] c, input logic [127:0] p, input int stall,
                           input bit keep_valid);
    bus.in_data   = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    acc_cyc = cyc;
    check("acc_in_ready", bus.in_ready, 1);
    check("acc_rk_idx", bus.rk_idx, 10);
    @(negedge clk);
    if (keep_valid) bus.in_data = '0;
    else            bus.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check("rnd_rk_idx", bus.rk_idx, 128'(10 - k));
      check("rnd_busy", bus.busy, 1);
      check("rnd_out_valid", bus.out_valid, 0);
      check("rnd_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    for (int s = 0; s < stall; s++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, p);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_busy", bus.busy, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("done_out_valid", bus.out_valid, 1);
    check("done_out_data", bus.out_data, p);
    check("done_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("post_out_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
    check("post_out_data", bus.out_data, 0);
  endtask

  initial begin
    rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values during and after reset
    @(negedge clk);
    check_idle_outputs("rst_during");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_after");

    // FIPS-197 C.1 with out_ready high
    run_block(CT, PT, 0, 1'b0);

    // Backpressure for 5 cycles
    run_block(CT, PT, 5, 1'b0);

    // in_valid held with a zero block throughout; it must be taken right after the handshake
    run_block(CT, PT, 0, 1'b1);
    @(negedge clk);
    check("busy_in_second_acc", bus.busy, 1);
    check("busy_in_second_idx", bus.rk_idx, 9);
    bus.in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("drain_timeout", bus.out_valid, 1);
    end
    @(negedge clk);
    check("drain_idle", bus.in_ready, 1);

    // Reset at cycle T+5 of a decryption
    bus.in_data   = CT;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    check_idle_outputs("rst_mid_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid_after");
    run_block(CT, PT, 0, 1'b0);

    // Back-to-back: second block uses masked key store, expected PT^Y
    run_block(CT, PT, 0, 1'b0);
    acc_prev = acc_cyc;
    alt = 1'b1;
    run_block(CT ^ X_M, PT ^ Y_M, 0, 1'b0);
    alt = 1'b0;
    check("b2b_spacing", 128'(acc_cyc - acc_prev), 12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
